// File: rtl/caja_musica_pkg.sv
// Shared music-box constants: note indices, tone frequencies and the
// reference-period helper used by both the tone generator and the detector.
package caja_musica_pkg;

  localparam int NUM_NOTAS = 7;

  localparam int NOTA_DO  = 6;
  localparam int NOTA_RE  = 5;
  localparam int NOTA_MI  = 4;
  localparam int NOTA_FA  = 3;
  localparam int NOTA_SOL = 2;
  localparam int NOTA_LA  = 1;
  localparam int NOTA_SI  = 0;

  // Index 0 is do, 6 is si (ascending pitch).
  localparam int F_NOTA [NUM_NOTAS] = '{262, 294, 330, 349, 392, 440, 494};

  typedef logic [NUM_NOTAS-1:0] teclas_t;
  typedef logic [2:0]           nota_idx_t;

  typedef enum logic [1:0] {IDLE, ARMED, LOCKED} estado_t;

  function automatic int ref_periodo(input int clk_hz, input int k);
    return clk_hz / F_NOTA[3'(k)];
  endfunction

  // Note index 0 (do) lands on bit NOTA_DO, index 6 (si) on bit NOTA_SI.
  function automatic teclas_t nota_onehot(input nota_idx_t k);
    return teclas_t'(1) << (3'(NOTA_DO) - k);
  endfunction

endpackage

// File: rtl/detector_nota_if.sv
// Tone-in / note-out bundle of the detector; master is the detector side.
interface detector_nota_if
  import caja_musica_pkg::*;
#(
  parameter int CNT_W = 18
);
  logic             tono_in;
  teclas_t          teclas;
  logic             nota_valida;
  logic [CNT_W-1:0] periodo;

  modport master (input tono_in, output teclas, nota_valida, periodo);
  modport slave  (output tono_in, input teclas, nota_valida, periodo);
endinterface

// File: rtl/detector_nota_flanco.sv
// 2-FF synchroniser for an asynchronous input plus a registered one-cycle
// pulse on each synchronised 0->1 transition.
module detector_flanco (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic flanco
);
  logic [1:0] sync;
  logic       prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      prev   <= 1'b0;
      flanco <= 1'b0;
    end else begin
      sync   <= {sync[0], d};
      prev   <= sync[1];
      flanco <= sync[1] & ~prev;
    end
  end
endmodule

// File: rtl/detector_nota.sv
// Tone period detector: measures the rising-edge period of tono_in and
// re-emits the matching note as a one-hot key once it has been stable.
module detector_nota
  import caja_musica_pkg::*;
#(
  parameter int CLK_HZ    = 25_000_000,
  parameter int TOL_SHIFT = 6,
  parameter int STABLE_N  = 2,
  parameter int CNT_W     = 18
) (
  input logic             clk,
  input logic             rst_n,
  detector_nota_if.master bus
);

  localparam int TIMEOUT = 2 * ref_periodo(CLK_HZ, 0);
  localparam int MW      = $clog2(STABLE_N + 1);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [MW-1:0]    match_t;

  localparam cnt_t TIMEOUT_C = cnt_t'(TIMEOUT);

  function automatic cnt_t win_lo(input int k);
    int r;
    r = ref_periodo(CLK_HZ, k);
    return cnt_t'(r - (r >> TOL_SHIFT));
  endfunction

  function automatic cnt_t win_hi(input int k);
    int r;
    r = ref_periodo(CLK_HZ, k);
    return cnt_t'(r + (r >> TOL_SHIFT));
  endfunction

  logic      flanco;
  estado_t   estado_q, estado_d;
  nota_idx_t cand_q, cand_d;
  match_t    match_q, match_d;
  cnt_t      cnt_q, cnt_d;
  teclas_t   teclas_q, teclas_d;
  logic      valida_q, valida_d;
  cnt_t      periodo_q, periodo_d;

  logic      hit;
  nota_idx_t k_hit;
  logic      timeout;
  logic      lock;

  detector_flanco u_flanco (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (bus.tono_in),
    .flanco (flanco)
  );

  // Walk from si down to do so the lowest matching index wins.
  always_comb begin
    hit   = 1'b0;
    k_hit = '0;
    for (int k = NUM_NOTAS - 1; k >= 0; k--) begin
      if (cnt_q >= win_lo(k) && cnt_q <= win_hi(k)) begin
        hit   = 1'b1;
        k_hit = nota_idx_t'(k);
      end
    end
  end

  always_comb begin
    estado_d  = estado_q;
    cand_d    = cand_q;
    match_d   = match_q;
    teclas_d  = teclas_q;
    valida_d  = valida_q;
    periodo_d = periodo_q;
    lock      = 1'b0;
    timeout   = (cnt_q == TIMEOUT_C);
    cnt_d     = timeout ? cnt_q : cnt_q + cnt_t'(1);

    if (timeout) begin
      estado_d = IDLE;
      match_d  = '0;
      teclas_d = '0;
      valida_d = 1'b0;
    end

    // An edge coinciding with the timeout only re-arms: the count is stale.
    if (flanco) begin
      cnt_d = cnt_t'(1);
      if (timeout || estado_q == IDLE) begin
        estado_d = ARMED;
      end else begin
        periodo_d = cnt_q;
        if (!hit) begin
          teclas_d = '0;
          valida_d = 1'b0;
          match_d  = '0;
          estado_d = ARMED;
        end else if (match_q != '0 && k_hit == cand_q) begin
          if (match_q != match_t'(STABLE_N))
            match_d = match_q + match_t'(1);
          lock = (match_q >= match_t'(STABLE_N - 1));
        end else begin
          // New candidate: outputs keep the old note until it is confirmed.
          cand_d  = k_hit;
          match_d = match_t'(1);
          lock    = (STABLE_N == 1);
        end
        if (lock) begin
          teclas_d = nota_onehot(k_hit);
          valida_d = 1'b1;
          estado_d = LOCKED;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= IDLE;
      cand_q    <= '0;
      match_q   <= '0;
      cnt_q     <= '0;
      teclas_q  <= '0;
      valida_q  <= 1'b0;
      periodo_q <= '0;
    end else begin
      estado_q  <= estado_d;
      cand_q    <= cand_d;
      match_q   <= match_d;
      cnt_q     <= cnt_d;
      teclas_q  <= teclas_d;
      valida_q  <= valida_d;
      periodo_q <= periodo_d;
    end
  end

  assign bus.teclas      = teclas_q;
  assign bus.nota_valida = valida_q;
  assign bus.periodo     = periodo_q;

endmodule
